layer_epoch_sequencer: RTL

//  Parametrised control successor to the single-layer top. Sequences a batch of input samples through one

---
 rtl/layer_epoch_sequencer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/layer_epoch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : layer_epoch_sequencer
// Purpose  : Batch sequencer for one spiking layer. Per sample it fetches,
//            sweeps time, captures the first spike and reports the winner.
// Options  : EARLY_TERMINATE_EN - end the sweep early once inference finds a winner
// Revision : 1.0 - initial release
// ============================================================================
module layer_epoch_sequencer #(
    parameter int NUM_NEURONS = 8,
    parameter int NEURON_W    = 3,
    parameter int TIME_PERIOD = 16,
    parameter int TIME_W      = 5,
    parameter int SAMPLE_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst_l,
    input  logic                   start,
    input  logic [SAMPLE_W-1:0]    num_samples,
    input  logic                   train_mode,
    output logic                   sample_req,
    input  logic                   sample_ack,
    output logic [TIME_W-1:0]      time_val,
    output logic                   training,
    output logic                   layer_clr,
    input  logic [NUM_NEURONS-1:0] neuron_spike,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [NEURON_W-1:0]    res_neuron,
    output logic [TIME_W-1:0]      res_time,
    output logic                   res_nospike,
    output logic                   busy,
    output logic                   done,
    output logic [SAMPLE_W-1:0]    sample_idx
);

    localparam logic [2:0] c_s_idle   = 3'd0;
    localparam logic [2:0] c_s_fetch  = 3'd1;
    localparam logic [2:0] c_s_run    = 3'd2;
    localparam logic [2:0] c_s_report = 3'd3;
    localparam logic [2:0] c_s_clear  = 3'd4;

    localparam logic [TIME_W-1:0] c_last_time = TIME_W'(TIME_PERIOD - 1);
    localparam logic [TIME_W-1:0] c_nospike   = TIME_W'(TIME_PERIOD);

    logic [2:0]          r_state;
    logic [2:0]          w_next_state;
    logic [TIME_W-1:0]   r_time;
    logic [SAMPLE_W-1:0] r_num;
    logic [SAMPLE_W-1:0] r_idx;
    logic                r_training;
    logic                r_found;
    logic [NEURON_W-1:0] r_res_neuron;
    logic [TIME_W-1:0]   r_res_time;
    logic                r_res_nospike;
    logic                r_done_zero;

    logic                w_accept;
    logic                w_run_entry;
    logic                w_last_sample;
    logic                w_any_spike;
    logic                w_early;
    logic [NEURON_W-1:0] w_low_idx;

    assign w_accept      = (r_state == c_s_idle) && start && (num_samples != '0);
    assign w_run_entry   = (r_state == c_s_fetch) && sample_ack;
    assign w_last_sample = (r_idx == (r_num - SAMPLE_W'(1)));
    assign w_any_spike   = |neuron_spike;

`ifdef EARLY_TERMINATE_EN
    assign w_early = r_found && !r_training;
`else
    assign w_early = 1'b0;
`endif

    // Descending scan so the lowest set index is the one left standing.
    always_comb begin
        w_low_idx = '0;
        for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
            if (neuron_spike[i]) begin
                w_low_idx = NEURON_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state <= c_s_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_s_idle:   if (w_accept) w_next_state = c_s_fetch;
            c_s_fetch:  if (sample_ack) w_next_state = c_s_run;
            c_s_run:    if ((r_time == c_last_time) || w_early) w_next_state = c_s_report;
            c_s_report: if (res_ready) w_next_state = c_s_clear;
            c_s_clear:  w_next_state = w_last_sample ? c_s_idle : c_s_fetch;
            default:    w_next_state = c_s_idle;
        endcase
    end

    always_comb begin
        sample_req  = (r_state == c_s_fetch);
        res_valid   = (r_state == c_s_report);
        layer_clr   = (r_state == c_s_clear);
        busy        = (r_state != c_s_idle);
        done        = ((r_state == c_s_clear) && w_last_sample) || r_done_zero;
        time_val    = (r_state == c_s_run) ? r_time : '0;
        training    = r_training;
        sample_idx  = r_idx;
        res_neuron  = r_res_neuron;
        res_time    = r_res_time;
        res_nospike = r_res_nospike;
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_time        <= '0;
            r_num         <= '0;
            r_idx         <= '0;
            r_training    <= 1'b0;
            r_found       <= 1'b0;
            r_res_neuron  <= '0;
            r_res_time    <= '0;
            r_res_nospike <= 1'b0;
            r_done_zero   <= 1'b0;
        end else begin
            r_done_zero <= (r_state == c_s_idle) && start && (num_samples == '0);

            if (w_accept) begin
                r_num      <= num_samples;
                r_training <= train_mode;
                r_idx      <= '0;
            end else if ((r_state == c_s_clear) && !w_last_sample) begin
                r_idx <= r_idx + SAMPLE_W'(1);
            end

            if ((r_state == c_s_run) && (w_next_state == c_s_run)) begin
                r_time <= r_time + TIME_W'(1);
            end else begin
                r_time <= '0;
            end

            // Only the first spiking cycle of a sample is captured.
            if (w_run_entry) begin
                r_found       <= 1'b0;
                r_res_neuron  <= '0;
                r_res_time    <= '0;
                r_res_nospike <= 1'b0;
            end else if ((r_state == c_s_run) && !r_found) begin
                if (w_any_spike) begin
                    r_found      <= 1'b1;
                    r_res_neuron <= w_low_idx;
                    r_res_time   <= r_time;
                end else if (w_next_state == c_s_report) begin
                    r_res_nospike <= 1'b1;
                    r_res_time    <= c_nospike;
                end
            end
        end
    end

endmodule
`default_nettype wire
